mt_seeder: RTL

- Upstream initialisation stage for the Mersenne Twister core (default MT19937).
- Accepts one W-bit seed and expands it into the N-word initial state with the standard recurrence x[i] = F*(x[i-1] ^ (x[i-1] >> (W-2))) + i, mod 2^W.
- Streams the words one per cycle on load_value/value into the twister's load port.
- Provides a seeded status that the system uses to gate gen_rv.

---
 rtl/mt_seeder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mt_seeder.sv
// Mersenne Twister seed expander: streams N initial state words from one seed.
// Optional MT_SEEDER_RESEED_EN: accept a new seed during LOAD and restart.
module mt_seeder #(
   parameter int unsigned  W = 32,
   parameter int unsigned  N = 624,
   parameter logic [W-1:0] F = 32'd1812433253
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         seed_valid,
   input  logic [W-1:0] seed,
   output logic         seed_ready,
   output logic         load_value,
   output logic [W-1:0] value,
   output logic         busy,
   output logic         done,
   output logic         seeded
);

   localparam int unsigned  IW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_FIN
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_index;
   logic [IW-1:0] w_index_nxt;
   logic [W-1:0]  r_value;
   logic [W-1:0]  w_value_nxt;
   logic          r_load_value;
   logic          w_load_nxt;
   logic          r_busy;
   logic          w_busy_nxt;
   logic          r_done;
   logic          w_done_nxt;
   logic          r_seeded;
   logic          w_seeded_nxt;
   logic          w_accept;
   logic [W-1:0]  w_mix;
   logic [W-1:0]  w_prod;
   logic [W-1:0]  w_next;

`ifdef MT_SEEDER_RESEED_EN
   assign seed_ready = (r_state == S_IDLE) || (r_state == S_FIN) ||
                       (r_state == S_LOAD);
`else
   assign seed_ready = (r_state == S_IDLE) || (r_state == S_FIN);
`endif

   assign w_accept = seed_valid && seed_ready;

   // x[i] = F*(x[i-1] ^ (x[i-1] >> (W-2))) + i, low W bits only
   assign w_mix  = r_value ^ (r_value >> (W - 2));
   assign w_prod = F * w_mix;
   assign w_next = w_prod + W'(r_index) + W'(1'b1);

   always_comb begin
      w_state_nxt  = r_state;
      w_index_nxt  = r_index;
      w_value_nxt  = r_value;
      w_load_nxt   = r_load_value;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_seeded_nxt = r_seeded;
      unique case (r_state)
         S_IDLE, S_FIN: begin
            if (w_accept) begin
               w_state_nxt = S_LOAD;
               w_value_nxt = seed;
               w_index_nxt = '0;
               w_load_nxt  = 1'b1;
               w_busy_nxt  = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            if (w_accept) begin
               w_value_nxt = seed;
               w_index_nxt = '0;
            end else if (r_index == LAST) begin
               w_state_nxt  = S_FIN;
               w_load_nxt   = 1'b0;
               w_busy_nxt   = 1'b0;
               w_done_nxt   = 1'b1;
               w_seeded_nxt = 1'b1;
            end else begin
               w_value_nxt = w_next;
               w_index_nxt = r_index + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_load_nxt  = 1'b0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state      <= S_IDLE;
         r_index      <= '0;
         r_value      <= '0;
         r_load_value <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_seeded     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_index      <= w_index_nxt;
         r_value      <= w_value_nxt;
         r_load_value <= w_load_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_seeded     <= w_seeded_nxt;
      end
   end

   assign load_value = r_load_value;
   assign value      = r_value;
   assign busy       = r_busy;
   assign done       = r_done;
   assign seeded     = r_seeded;

endmodule
